// File: rtl/iir_decim_fifo.sv
// Decimating stage behind the IIR filter.
// Each block of 2^DECIM_LOG2 strobed Q1.15 samples is reduced to one rounded
// average (round half up). The averages are queued in a first-word-fall-through
// FIFO and leave through a valid/ready handshake. A sticky flag records every
// average that was dropped because the FIFO was full.
module iir_decim_fifo #(
    parameter int inout_width = 16,
    parameter int DECIM_LOG2  = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          en_i,
    input  logic [inout_width-1:0]        data_i,
    output logic [inout_width-1:0]        data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_o,
    output logic                          overflow_o,
    input  logic                          clear_i
);

    localparam int AW   = inout_width + DECIM_LOG2;
    localparam int PW   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CW   = PTRW + 1;
    localparam int RND  = (2 ** DECIM_LOG2) / 2;
    localparam logic [PW-1:0] LAST_PHASE = PW'((2 ** DECIM_LOG2) - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [PW-1:0]          phase_q, phase_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [PTRW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [inout_width-1:0] mem_q [FIFO_DEPTH];

    logic signed [AW:0]     total;
    logic signed [AW:0]     rounded;
    logic [inout_width-1:0] avg;
    logic                   complete;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    // Block accumulation, rounding and phase sequencing.
    // The extra headroom bit keeps the rounding term from wrapping the sum.
    always_comb begin
        total    = (AW+1)'($signed(acc_q)) + (AW+1)'($signed(data_i));
        rounded  = total + (AW+1)'(RND);
        avg      = inout_width'(rounded >>> DECIM_LOG2);
        complete = en_i && (phase_q == LAST_PHASE);
        phase_d  = phase_q;
        acc_d    = acc_q;
        if (en_i) begin
            if (complete) begin
                phase_d = '0;
                acc_d   = '0;
            end else begin
                phase_d = phase_q + PW'(1);
                acc_d   = AW'(total);
            end
        end
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        valid_o  = (count_q != '0);
        full     = (count_q == FULL_COUNT);
        pop      = valid_o && ready_i;
        push     = complete && (!full || pop);
        drop     = complete && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_i) begin
            overflow_d = 1'b0;
        end
    end

    // Output view of the FIFO head and status.
    always_comb begin
        data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
        fill_o     = count_q;
        overflow_o = overflow_q;
    end

    // Control state register; a partial block is discarded on reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase_q    <= '0;
            acc_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write; contents are left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= avg;
        end
    end

endmodule

// File: doc/iir_decim_fifo.md
Name: iir_decim_fifo

Overview:
- Stage directly downstream of the IIR filter.
- Takes the filter's signed Q1.15 output samples, decimates them by 2^DECIM_LOG2 using a rounded block average (accumulate-and-dump), and buffers the results in a small first-word-fall-through FIFO.
- Results leave through a valid/ready handshake, decoupling the free-running filter from a back-pressuring consumer.
- FIFO overflow is reported through a sticky flag.

Parameters:
- inout_width, 16, sample width (signed Q1.15).
- DECIM_LOG2, 2, log2 of the decimation ratio N (N = 4 at default); 0 means pass-through.
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- clk_i, input, 1, clock; all state changes on the rising edge.
- reset_ni, input, 1, asynchronous active-low reset.
- en_i, input, 1, sample strobe: data_i is consumed on a rising edge when en_i = 1.
- data_i, input, inout_width, signed input sample from the IIR filter output.
- data_o, output, inout_width, signed decimated sample at the FIFO head; 0 when valid_o = 0.
- valid_o, output, 1, FIFO non-empty.
- ready_i, input, 1, consumer accepts data_o.
- fill_o, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- overflow_o, output, 1, sticky: a completed average was dropped because the FIFO was full.
- clear_i, input, 1, synchronous clear of overflow_o.

Behaviour:
- Reset (reset_ni = 0, asynchronous): phase counter = 0, accumulator = 0, FIFO pointers = 0.
  - Outputs during reset: fill_o = 0, valid_o = 0, data_o = 0, overflow_o = 0.
  - FIFO storage is not reset.
  - A partially accumulated block is discarded. After reset release, the first en_i sample starts a new block.
- Accumulator:
  - Signed, inout_width + DECIM_LOG2 bits.
  - Phase counter is DECIM_LOG2 bits. It advances only on en_i cycles and wraps from N-1 to 0.
  - en_i = 0: accumulator and counter hold.
- Block completion (en_i = 1 and phase = N-1):
  - total = acc + data_i.
  - avg = (total + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. arithmetic shift, round half up.
  - The result is always within [-32768, 32767], so no saturation is needed. Truncate avg to inout_width.
  - The accumulator reloads to 0 on the same edge.
  - DECIM_LOG2 = 0: no rounding term, and every en_i sample is pushed unchanged.
- Push: on a completion edge.
- Pop: on any edge where valid_o = 1 and ready_i = 1.
- Latency: the average is pushed on the edge that accepts the Nth sample. It is visible on data_o with valid_o = 1 from the next cycle, provided the FIFO was empty. There is no combinational bypass from data_i to data_o.
- FIFO:
  - First-word-fall-through: data_o = mem[rd_ptr] while valid_o = 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - Output order equals push order.
  - Push and pop in the same cycle: both happen and fill_o is unchanged.
  - Full, push with pop in the same cycle: the push is accepted and no overflow occurs.
  - Full, push without pop: the average is dropped, fill_o stays FIFO_DEPTH, overflow_o goes to 1 next cycle, FIFO contents are unchanged, and decimation continues uninterrupted.
  - Empty: ready_i is ignored and no pop occurs.
- overflow_o:
  - Cleared by clear_i = 1.
  - If a drop and clear_i occur in the same cycle, set wins and overflow_o = 1.
- valid_o must not depend combinationally on ready_i.

Test Plan:
- Reset values: hold reset_ni = 0 mid-traffic → immediately valid_o = 0, data_o = 0, fill_o = 0, overflow_o = 0.
- Averaging: N = 4, ready_i = 1, en_i = 1, feed 100, 200, 300, 400 → one cycle after the 4th edge, data_o = 250 with valid_o = 1 for exactly 1 cycle, then fill_o = 0.
- Rounding: feed 1, 1, 1, 2 → data_o = 1. Feed -1, -1, -1, -2 → data_o = -1. Feed 4 × 32767 → data_o = 32767. Feed 4 × -32768 → data_o = -32768.
- Strobe gaps: feed 10, (en_i = 0, data_i = 9999), 20, 30, 40 → data_o = 25; the gap value is ignored.
- Back-pressure and overflow:
  - ready_i = 0, push 9 blocks whose averages are 1..9 → fill_o = 8 and overflow_o = 1 after the 9th.
  - Then ready_i = 1 → drains 1..8 in order, then valid_o = 0.
  - Then clear_i → overflow_o = 0.
- Boundary events:
  - With FIFO full, complete a block in the same cycle as a pop → fill_o stays 8 and overflow_o stays 0.
  - Pulse reset_ni after 2 samples of a block, then feed 4, 8, 12, 16 → data_o = 10.
